// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int DATA_W = 16;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane extract (with sign/zero extension) for loads and lane replace for stores.
// Present only when LSU_BYTE_EN is defined.
`ifdef LSU_BYTE_EN
module byte_lane_merge
    import lsu_pkg::*;
(
    input  logic              lane_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0] sel;

    always_comb begin
        sel     = (lane_i == LANE_HI) ? word_i[15:8] : word_i[7:0];
        load_o  = {(signed_i ? {8{sel[7]}} : 8'h00), sel};
        merge_o = (lane_i == LANE_LO) ? {word_i[15:8], byte_i} : {byte_i, word_i[7:0]};
    end

endmodule
`endif

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer for a 16-bit word-addressed data memory.
// Byte loads/stores (read-modify-write) are built only when LSU_BYTE_EN is defined.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic              accept;
    logic              is_byte;
    logic              misaligned;
    logic              rmw;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merge_val;

    assign accept     = req_valid && (state_q == IDLE);
    assign misaligned = req_addr[0] && !is_byte;

`ifdef LSU_BYTE_EN
    logic       write_q, byte_q, signed_q;
    logic [7:0] bdata_q;
    logic [DATA_W-1:0] ext_val;

    assign is_byte  = req_byte;
    assign rmw      = write_q;
    assign load_val = byte_q ? ext_val : mem_read_data;

    byte_lane_merge u_lane (
        .lane_i   (addr_q[0]),
        .signed_i (signed_q),
        .word_i   (mem_read_data),
        .byte_i   (bdata_q),
        .load_o   (ext_val),
        .merge_o  (merge_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            bdata_q  <= '0;
        end else if (accept) begin
            write_q  <= req_write;
            byte_q   <= req_byte;
            signed_q <= req_signed;
            bdata_q  <= req_wdata[7:0];
        end
    end
`else
    logic unused_byte_ctl;
    assign unused_byte_ctl = &{1'b0, req_byte, req_signed};
    assign is_byte   = 1'b0;
    assign rmw       = 1'b0;
    assign load_val  = mem_read_data;
    assign merge_val = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)                state_d = RESP;
                    else if (is_byte || !req_write) state_d = RD;
                    else                           state_d = WR;
                end
            end
            RD:      state_d = rmw ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are registered from the next state so they line up with RD/WR.
    always_comb begin
        addr_d  = accept ? req_addr : addr_q;
        rd_d    = (state_d == RD);
        we_d    = (state_d == WR);
        wdata_d = '0;
        if (state_d == WR)
            wdata_d = (state_q == RD) ? merge_val : req_wdata;

        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q != RESP && state_d == RESP) begin
            err_d   = (state_q == IDLE);
            rdata_d = (state_q == RD) ? load_val : '0;
        end else if (state_q == RESP && state_d == IDLE) begin
            err_d   = 1'b0;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign rsp_valid       = (state_q == RESP);
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;
    assign mem_read        = rd_q;
    assign mem_write_en    = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios (byte ones need LSU_BYTE_EN).
module tb_load_store_unit;

`ifdef LSU_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_read;
    logic        mem_write_en;
    logic [15:0] mem_read_data;

    load_store_unit #(.ADDR_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_byte        (req_byte),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_read        (mem_read),
        .mem_write_en    (mem_write_en),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write at the rising edge, no reset.
    logic        mem_clr = 1'b1;
    logic [15:0] mem [0:255];
    assign mem_read_data = mem[mem_access_addr[8:1]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_write_en) begin
            mem[mem_access_addr[8:1]] <= mem_write_data;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    // Transaction model: kind 0 load, 1 word store, 2 byte store, 3 misaligned.
    localparam int K_LD = 0, K_WST = 1, K_BST = 2, K_ERR = 3;
    logic [15:0] m_mem [0:255];
    bit          m_act = 1'b0;
    int          m_E = 0;
    int          m_kind = 0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_rdata = '0;
    logic [15:0] m_wword = '0;
    logic        m_err = 1'b0;

    initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

    function automatic int first_rsp(input int k);
        case (k)
            K_LD, K_WST: return 1;
            K_BST:       return 2;
            default:     return 0;
        endcase
    endfunction

    function automatic int rd_at(input int k);
        return (k == K_LD || k == K_BST) ? 0 : -1;
    endfunction

    function automatic int wr_at(input int k);
        case (k)
            K_WST:   return 0;
            K_BST:   return 1;
            default: return -1;
        endcase
    endfunction

    // Compare, then advance the model to what the next edge does.
    always @(negedge clk) begin
        int          rel;
        bit          in_resp, in_rd, in_wr, bt;
        logic [15:0] w;
        logic [7:0]  b;
        rel     = cyc - m_E;
        in_resp = m_act && (rel >= first_rsp(m_kind));
        in_rd   = m_act && (rel == rd_at(m_kind));
        in_wr   = m_act && (rel == wr_at(m_kind));

        chk1("req_ready", req_ready, !m_act);
        chk1("rsp_valid", rsp_valid, in_resp);
        if (in_resp) begin
            chk16("rsp_rdata", rsp_rdata, m_rdata);
            chk1("rsp_err", rsp_err, m_err);
        end
        chk1("mem_read", mem_read, in_rd);
        chk1("mem_write_en", mem_write_en, in_wr);
        chk16("mem_write_data", mem_write_data, in_wr ? m_wword : 16'h0000);
        chk16("mem_access_addr", mem_access_addr, m_addr);

        if (in_wr) m_mem[m_addr[8:1]] = m_wword;
        if (rst) begin
            m_act  = 1'b0;
            m_addr = '0;
        end else if (m_act) begin
            if (in_resp && rsp_ready) m_act = 1'b0;
        end else if (req_valid) begin
            m_act   = 1'b1;
            m_E     = cyc + 1;
            m_addr  = req_addr;
            w       = m_mem[req_addr[8:1]];
            b       = req_addr[0] ? w[15:8] : w[7:0];
            bt      = BYTE_EN && req_byte;
            m_rdata = '0;
            m_err   = 1'b0;
            m_wword = '0;
            if (req_addr[0] && !bt) begin
                m_kind = K_ERR;
                m_err  = 1'b1;
            end else if (req_write && bt) begin
                m_kind  = K_BST;
                m_wword = req_addr[0] ? {req_wdata[7:0], w[7:0]} : {w[15:8], req_wdata[7:0]};
            end else if (req_write) begin
                m_kind  = K_WST;
                m_wword = req_wdata;
            end else begin
                m_kind  = K_LD;
                m_rdata = bt ? {(req_signed ? {8{b[7]}} : 8'h00), b} : w;
            end
        end
    end

    // Issue one request; rst_at >= 0 pulses rst that many cycles after the accept edge.
    task automatic txn(input bit w, input bit bsel, input bit s, input logic [15:0] a,
                       input logic [15:0] wd, input int hold, input int rst_at,
                       output logic [15:0] rd, output logic er);
        int n, held;
        bit got;
        rd = '0; er = 1'b0; n = 0; held = 0; got = 1'b0;
        req_write = w; req_byte = bsel; req_signed = s; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!m_act && n < 20);
        req_valid = 1'b0;
        if (!m_act) chk1("accept_timeout", 1'b0, 1'b1);
        n = 0;
        while (m_act && n < 60) begin
            rst = (rst_at == n);
            if ((cyc - m_E) >= first_rsp(m_kind)) begin
                if (!got) begin rd = rsp_rdata; er = rsp_err; got = 1'b1; end
                if (held >= hold) rsp_ready = 1'b1;
                else held++;
            end
            @(posedge clk); #1; n++;
        end
        if (m_act) chk1("rsp_timeout", 1'b0, 1'b1);
        rst = 1'b0;
        rsp_ready = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_clr = 1'b0;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk16("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk16("rst_addr", mem_access_addr, 16'h0000);
        chk16("rst_wdata", mem_write_data, 16'h0000);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_we", mem_write_en, 1'b0);

        txn(1, 0, 0, 16'h0010, 16'hBEEF, 0, -1, rd, er);
        txn(0, 0, 0, 16'h0010, 16'h0000, 0, -1, rd, er);
        chk16("wld_0010", rd, 16'hBEEF);
        chk1("wld_0010_err", er, 1'b0);

        txn(1, 0, 0, 16'h0020, 16'h1234, 0, -1, rd, er);
        txn(1, 1, 0, 16'h0021, 16'h00AB, 0, -1, rd, er);
`ifdef LSU_BYTE_EN
        chk16("bst_0021", mem[8'h10], 16'hAB34);
`else
        chk16("bst_0021_noop", mem[8'h10], 16'h1234);
        chk1("bst_0021_err", er, 1'b1);
`endif
        txn(1, 1, 0, 16'h0020, 16'h00CD, 0, -1, rd, er);
`ifdef LSU_BYTE_EN
        chk16("bst_0020", mem[8'h10], 16'hABCD);
`else
        chk16("wst_0020", mem[8'h10], 16'h00CD);
`endif

        txn(1, 0, 0, 16'h0030, 16'h80F0, 0, -1, rd, er);
        txn(0, 1, 1, 16'h0031, 16'h0000, 0, -1, rd, er);
`ifdef LSU_BYTE_EN
        chk16("bld_s_0031", rd, 16'hFF80);
`else
        chk1("bld_s_0031_err", er, 1'b1);
`endif
        txn(0, 1, 0, 16'h0031, 16'h0000, 0, -1, rd, er);
`ifdef LSU_BYTE_EN
        chk16("bld_u_0031", rd, 16'h0080);
`else
        chk16("bld_u_0031_rd", rd, 16'h0000);
`endif
        txn(0, 1, 1, 16'h0030, 16'h0000, 0, -1, rd, er);
`ifdef LSU_BYTE_EN
        chk16("bld_s_0030", rd, 16'hFFF0);
`else
        chk16("wld_0030", rd, 16'h80F0);
`endif

        txn(0, 0, 0, 16'h0041, 16'h0000, 0, -1, rd, er);
        chk1("mis_ld_err", er, 1'b1);
        chk16("mis_ld_rd", rd, 16'h0000);
        txn(1, 0, 0, 16'h0043, 16'h5555, 0, -1, rd, er);
        chk1("mis_st_err", er, 1'b1);

        txn(0, 0, 0, 16'h0010, 16'h0000, 5, -1, rd, er);
        chk16("bp_ld_0010", rd, 16'hBEEF);

        txn(1, 0, 0, 16'h0050, 16'h1111, 0, -1, rd, er);
        txn(1, 1, 0, 16'h0050, 16'h0022, 0, 0, rd, er);
`ifdef LSU_BYTE_EN
        chk16("rst_rd_nowrite", mem[8'h28], 16'h1111);
`else
        chk16("rst_wr_lands", mem[8'h28], 16'h0022);
`endif
        chk16("rst_mid_addr", mem_access_addr, 16'h0000);
        chk1("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_mid_req_ready", req_ready, 1'b1);

        txn(1, 0, 0, 16'h0060, 16'h5A5A, 0, 0, rd, er);
        chk16("rst_wr_5a5a", mem[8'h30], 16'h5A5A);

        // Reset coincident with a request: nothing is accepted.
        req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
        rst = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        chk1("rst_req_mem_read", mem_read, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);

        txn(0, 0, 0, 16'h0050, 16'h0000, 0, -1, rd, er);
`ifdef LSU_BYTE_EN
        chk16("wld_0050", rd, 16'h1111);
`else
        chk16("wld_0050", rd, 16'h0022);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
